// File: rtl/cordic_if.sv
// cordic_if: operation/result handshake bundle for the CORDIC rotation core
interface cordic_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] z_in;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               flip_x_in;
  logic               flip_y_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] cos_out;
  logic signed [15:0] sin_out;
  logic               busy;
  modport master (
    output in_valid, z_in, x_in, y_in, flip_x_in, flip_y_in, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, busy
  );
  modport slave (
    input  in_valid, z_in, x_in, y_in, flip_x_in, flip_y_in, out_ready,
    output in_ready, out_valid, cos_out, sin_out, busy
  );
endinterface

// File: rtl/cordic_rotation_core.sv
// cordic_rotation_core: iterative rotation-mode CORDIC, one micro-rotation per cycle
module cordic_rotation_core #(
  parameter int ITERATIONS = 16
) (
  input logic     clk,
  input logic     rst,
  cordic_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;
  localparam logic signed [15:0] ATAN [16] = '{
    16'sd12868, 16'sd7596, 16'sd4014, 16'sd2037, 16'sd1023, 16'sd512, 16'sd256, 16'sd128,
    16'sd64, 16'sd32, 16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1, 16'sd1
  };
  state_t             state;
  logic [3:0]         i;
  logic signed [17:0] x, y, xs, ys, x_n, y_n;
  logic signed [15:0] z, z_n;
  logic               fx, fy;
  function automatic logic signed [15:0] form(input logic signed [17:0] v, input logic f);
    logic signed [15:0] s;
    s = v > 18'sd32767 ? 16'sd32767 : v < -18'sd32768 ? -16'sd32768 : v[15:0];
    return f ? (s == -16'sd32768 ? 16'sd32767 : -s) : s;
  endfunction
  always_comb begin
    xs  = x >>> i;
    ys  = y >>> i;
    x_n = z[15] ? x + ys : x - ys;
    y_n = z[15] ? y - xs : y + xs;
    z_n = z[15] ? z + ATAN[i] : z - ATAN[i];
  end
  assign bus.in_ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      i             <= '0;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      fx            <= 1'b0;
      fy            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.cos_out   <= '0;
      bus.sin_out   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x        <= {{2{bus.x_in[15]}}, bus.x_in};
          y        <= {{2{bus.y_in[15]}}, bus.y_in};
          z        <= bus.z_in;
          fx       <= bus.flip_x_in;
          fy       <= bus.flip_y_in;
          i        <= '0;
          bus.busy <= 1'b1;
          state    <= ITERATE;
        end
        ITERATE: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          i <= i + 4'd1;
          if (i == 4'(ITERATIONS - 1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.cos_out   <= form(x_n, fx);
            bus.sin_out   <= form(y_n, fy);
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rotation_core.sv
// tb_cordic_rotation_core: random and directed checks against a behavioural CORDIC model
module tb_cordic_rotation_core;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cordic_if bus();
  cordic_rotation_core #(.ITERATIONS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  int atan_t [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1};
  typedef struct {int c; int s;} res_t;
  res_t q[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act >= exp - tol && act <= exp + tol) passed++;
    else $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
  endtask
  function automatic int fin(input int v, input bit f);
    int s;
    s = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    if (f) s = s == -32768 ? 32767 : -s;
    return s;
  endfunction
  function automatic void model(input int z0, input int x0, input int y0, input bit fx, input bit fy,
                                output int c, output int s);
    int x, y, z, tx;
    x = x0; y = y0; z = z0;
    for (int k = 0; k < N; k++) begin
      tx = x;
      if (z >= 0) begin
        x = x - (y >>> k); y = y + (tx >>> k); z = z - atan_t[k];
      end else begin
        x = x + (y >>> k); y = y - (tx >>> k); z = z + atan_t[k];
      end
      z = int'(shortint'(z));
    end
    c = fin(x, fx);
    s = fin(y, fy);
  endfunction
  always @(negedge clk) begin
    res_t r;
    if (rst) q.delete();
    else begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          chk("cos_vs_model", int'(bus.cos_out), q[0].c);
          chk("sin_vs_model", int'(bus.sin_out), q[0].s);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model(int'(bus.z_in), int'(bus.x_in), int'(bus.y_in), bus.flip_x_in, bus.flip_y_in, r.c, r.s);
        q.push_back(r);
      end
    end
  end
  task automatic run_op(input int z, input int x, input int y, input bit fx, input bit fy,
                        output int c, output int s, output int lat);
    @(posedge clk); #1;
    bus.z_in = 16'(z); bus.x_in = 16'(x); bus.y_in = 16'(y);
    bus.flip_x_in = fx; bus.flip_y_in = fy; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("in_ready_after_accept", int'(bus.in_ready), 0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    c = int'(bus.cos_out);
    s = int'(bus.sin_out);
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    int c, s, lat, seen, mc, ms;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int c, s, lat, seen, mc, ms, hc, hs;
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.z_in = '0; bus.x_in = '0; bus.y_in = '0; bus.flip_x_in = 1'b0; bus.flip_y_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cos", int'(bus.cos_out), 0);
    chk("rst_sin", int'(bus.sin_out), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    model(0, 9949, 0, 0, 0, mc, ms);
    chk_tol("model_pin_cos0", mc, 16384, 8);
    chk_tol("model_pin_sin0", ms, 0, 8);
    chk("fin_pin_flip_min", fin(-32768, 1), 32767);
    chk("fin_pin_sat_hi", fin(40000, 0), 32767);
    chk("fin_pin_sat_lo_flip", fin(-40000, 1), 32767);
    chk("fin_pin_flip", fin(100, 1), -100);
    run_op(0, 9949, 0, 0, 0, c, s, lat);
    chk("latency", lat, N + 1);
    chk_tol("zero_cos", c, 16384, 8);
    chk_tol("zero_sin", s, 0, 8);
    run_op(12868, 9949, 0, 0, 0, c, s, lat);
    chk("latency_pi4", lat, N + 1);
    chk_tol("pi4_cos", c, 11585, 8);
    chk_tol("pi4_sin", s, 11585, 8);
    run_op(-8578, 9949, 0, 1, 1, c, s, lat);
    chk_tol("m30_flip_cos", c, -14189, 8);
    chk_tol("m30_flip_sin", s, 8192, 8);
    run_op(0, 32767, 32767, 0, 0, c, s, lat);
    chk("sat_cos", c, 32767);
    chk("sat_sin", s, 32767);
    run_op(0, -32768, -32768, 1, 1, c, s, lat);
    chk("sat_flip_cos", c, 32767);
    chk("sat_flip_sin", s, 32767);
    bus.out_ready = 1'b0;
    run_op(4000, 9949, 0, 0, 1, hc, hs, lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.in_valid = k[0];
      bus.z_in = 16'($urandom); bus.x_in = 16'($urandom); bus.y_in = 16'($urandom);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_cos", int'(bus.cos_out), hc);
      chk("hold_sin", int'(bus.sin_out), hs);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    bus.z_in = 16'sd12868; bus.x_in = 16'sd9949; bus.y_in = '0;
    bus.flip_x_in = 1'b0; bus.flip_y_in = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cos", int'(bus.cos_out), 0);
    chk("midrst_sin", int'(bus.sin_out), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_out_valid", seen, 0);
    run_op(12868, 9949, 0, 0, 0, c, s, lat);
    chk("post_rst_latency", lat, N + 1);
    chk_tol("post_rst_cos", c, 11585, 8);
    chk_tol("post_rst_sin", s, 11585, 8);
    for (int k = 0; k < 40; k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      run_op(int'(16'($urandom)) - 32768, int'(16'($urandom)) - 32768, int'(16'($urandom)) - 32768,
             1'($urandom), 1'($urandom), c, s, lat);
      chk("rand_latency", lat, N + 1);
      if (!bus.out_ready) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
